// File: rtl/shared_ram_arbiter_pkg.sv
// Shared definitions for the 68K/Z80 shared-RAM arbiter.
//   state_e       : arbiter FSM states
//   owner_e       : which CPU owns the current BRAM access
//   SHARED_RAM_AW : byte address width of the shared RAM (also used by chip_select)
package shared_ram_arbiter_pkg;

  parameter int unsigned SHARED_RAM_AW = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_M68K = 1'b0,
    OWN_Z80  = 1'b1
  } owner_e;

endpackage : shared_ram_arbiter_pkg

// File: rtl/shared_ram_arbiter.sv
// Arbitrates one synchronous single-port BRAM between the 68000 and the sound Z80.
// Each access is IDLE (grant, drive addr/we) -> ACCESS (BRAM samples) -> CAPTURE
// (latch read data, mark done). A master is not regranted until its select drops,
// so 2-way round-robin alternates under contention.
// Ports:
//   clk, reset_n                    : clock, async active-low reset
//   m68k_cs/rw/lds_n/addr/din       : 68K request (low byte lane)
//   m68k_dout, m68k_dtack_n         : 68K read data {FF,byte} and registered DTACK
//   z80_cs/rd_n/wr_n/addr/din       : Z80 request
//   z80_dout, z80_wait_n            : Z80 read data and combinational WAIT
//   ram_addr/we/wdata, ram_rdata    : BRAM port (rdata valid 1 cycle after addr)
module shared_ram_arbiter
  import shared_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = SHARED_RAM_AW,
  parameter bit          RR_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m68k_cs,
  input  logic              m68k_rw,
  input  logic              m68k_lds_n,
  input  logic [ADDR_W-1:0] m68k_addr,
  input  logic [7:0]        m68k_din,
  output logic [15:0]       m68k_dout,
  output logic              m68k_dtack_n,
  input  logic              z80_cs,
  input  logic              z80_rd_n,
  input  logic              z80_wr_n,
  input  logic [ADDR_W-1:0] z80_addr,
  input  logic [7:0]        z80_din,
  output logic [7:0]        z80_dout,
  output logic              z80_wait_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  state_e              r_state;
  owner_e              r_owner;
  owner_e              r_last_grant;
  logic                r_m_done;
  logic                r_z_done;
  logic                r_is_read;
  logic [15:0]         r_m68k_dout;
  logic                r_m68k_dtack_n;
  logic [7:0]          r_z80_dout;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_we;
  logic [7:0]          r_ram_wdata;

  logic w_m_req;
  logic w_z_req;
  logic w_grant_z;
  logic w_m_wr;
  logic w_z_wr;

  // Request terms; done flags mask a master until it releases its select.
  assign w_m_req   = m68k_cs & ~r_m_done;
  assign w_z_req   = z80_cs & (~z80_rd_n | ~z80_wr_n) & ~r_z_done;
  // Z80 wins when alone, or on a tie when the 68K had the last grant.
  assign w_grant_z = w_z_req & (~w_m_req | (r_last_grant == OWN_M68K));
  // Upper-byte-only 68K writes do not touch the RAM.
  assign w_m_wr    = ~m68k_rw & ~m68k_lds_n;
  assign w_z_wr    = ~z80_wr_n;

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_owner        <= OWN_M68K;
      r_last_grant   <= owner_e'(RR_INIT);
      r_m_done       <= 1'b0;
      r_z_done       <= 1'b0;
      r_is_read      <= 1'b0;
      r_m68k_dout    <= 16'hFFFF;
      r_m68k_dtack_n <= 1'b1;
      r_z80_dout     <= 8'h00;
      r_ram_addr     <= '0;
      r_ram_we       <= 1'b0;
      r_ram_wdata    <= 8'h00;
    end else begin
      // Release terms first; a CAPTURE in the same cycle overrides them below.
      if (!m68k_cs) begin
        r_m_done       <= 1'b0;
        r_m68k_dtack_n <= 1'b1;
      end
      if (!z80_cs || (z80_rd_n && z80_wr_n)) begin
        r_z_done <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_m_req || w_z_req) begin
            r_state <= ACCESS;
            if (w_grant_z) begin
              r_owner      <= OWN_Z80;
              r_last_grant <= OWN_Z80;
              r_ram_addr   <= z80_addr;
              r_ram_wdata  <= z80_din;
              r_ram_we     <= w_z_wr;
              r_is_read    <= ~w_z_wr;
            end else begin
              r_owner      <= OWN_M68K;
              r_last_grant <= OWN_M68K;
              r_ram_addr   <= m68k_addr;
              r_ram_wdata  <= m68k_din;
              r_ram_we     <= w_m_wr;
              r_is_read    <= m68k_rw;
            end
          end
        end

        ACCESS: begin
          r_ram_we <= 1'b0;
          r_state  <= CAPTURE;
        end

        CAPTURE: begin
          r_state <= IDLE;
          if (r_owner == OWN_M68K) begin
            if (r_is_read) begin
              r_m68k_dout <= {8'hFF, ram_rdata};
            end
            r_m_done       <= 1'b1;
            // Only acknowledge if the 68K is still selecting us.
            r_m68k_dtack_n <= ~m68k_cs;
          end else begin
            if (r_is_read) begin
              r_z80_dout <= ram_rdata;
            end
            r_z_done <= 1'b1;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  assign m68k_dout    = r_m68k_dout;
  assign m68k_dtack_n = r_m68k_dtack_n;
  assign z80_dout     = r_z80_dout;
  assign z80_wait_n   = ~w_z_req;
  assign ram_addr     = r_ram_addr;
  assign ram_we       = r_ram_we;
  assign ram_wdata    = r_ram_wdata;

endmodule : shared_ram_arbiter

// File: tb/tb_shared_ram_arbiter.sv
// Directed bench for shared_ram_arbiter with a behavioural 2 KB synchronous BRAM.
module tb_shared_ram_arbiter;

  localparam int unsigned AW = 11;

  logic          clk;
  logic          reset_n;
  logic          m68k_cs;
  logic          m68k_rw;
  logic          m68k_lds_n;
  logic [AW-1:0] m68k_addr;
  logic [7:0]    m68k_din;
  logic [15:0]   m68k_dout;
  logic          m68k_dtack_n;
  logic          z80_cs;
  logic          z80_rd_n;
  logic          z80_wr_n;
  logic [AW-1:0] z80_addr;
  logic [7:0]    z80_din;
  logic [7:0]    z80_dout;
  logic          z80_wait_n;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  // Bench-side preload port into the BRAM model.
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_data;

  logic [7:0]    mem [0:(1<<AW)-1];
  int            we_cnt;
  int            we_snap;
  int            checks;
  int            failures;

  shared_ram_arbiter #(.ADDR_W(AW), .RR_INIT(1'b1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m68k_cs      (m68k_cs),
    .m68k_rw      (m68k_rw),
    .m68k_lds_n   (m68k_lds_n),
    .m68k_addr    (m68k_addr),
    .m68k_din     (m68k_din),
    .m68k_dout    (m68k_dout),
    .m68k_dtack_n (m68k_dtack_n),
    .z80_cs       (z80_cs),
    .z80_rd_n     (z80_rd_n),
    .z80_wr_n     (z80_wr_n),
    .z80_addr     (z80_addr),
    .z80_din      (z80_din),
    .z80_dout     (z80_dout),
    .z80_wait_n   (z80_wait_n),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous BRAM: read-before-write, data one cycle after address.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  initial we_cnt = 0;
  always @(posedge clk) begin
    if (ram_we) we_cnt <= we_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick(1);
    pre_we   = 1'b0;
  endtask

  task automatic m68k_release();
    m68k_cs    = 1'b0;
    m68k_rw    = 1'b1;
    m68k_lds_n = 1'b1;
    m68k_addr  = '0;
    m68k_din   = 8'h00;
  endtask

  task automatic z80_release();
    z80_cs   = 1'b0;
    z80_rd_n = 1'b1;
    z80_wr_n = 1'b1;
    z80_addr = '0;
    z80_din  = 8'h00;
  endtask

  task automatic m68k_start(input logic rw, input logic lds_n,
                            input logic [AW-1:0] a, input logic [7:0] d);
    m68k_cs    = 1'b1;
    m68k_rw    = rw;
    m68k_lds_n = lds_n;
    m68k_addr  = a;
    m68k_din   = d;
  endtask

  task automatic z80_start(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
    z80_cs   = 1'b1;
    z80_rd_n = wr;
    z80_wr_n = ~wr;
    z80_addr = a;
    z80_din  = d;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = 8'h00;
    m68k_release();
    z80_release();

    // Preload while in reset.
    preload(11'h123, 8'h5A);
    preload(11'h020, 8'h11);
    preload(11'h040, 8'h55);
    preload(11'h010, 8'h00);

    chk("rst_dtack_n", 32'(m68k_dtack_n), 32'h1);
    chk("rst_m68k_dout", 32'(m68k_dout), 32'hFFFF);
    chk("rst_z80_dout", 32'(z80_dout), 32'h00);
    chk("rst_ram_addr", 32'(ram_addr), 32'h000);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'h00);
    chk("rst_wait_n", 32'(z80_wait_n), 32'h1);
    reset_n = 1'b1;

    // 68K read alone.
    m68k_start(1'b1, 1'b0, 11'h123, 8'h00);
    tick(2);
    chk("rd68_dtack_n2", 32'(m68k_dtack_n), 32'h1);
    tick(1);
    chk("rd68_dtack_n3", 32'(m68k_dtack_n), 32'h0);
    chk("rd68_dout", 32'(m68k_dout), 32'hFF5A);
    tick(2);
    chk("rd68_dtack_hold", 32'(m68k_dtack_n), 32'h0);
    m68k_release();
    tick(1);
    chk("rd68_dtack_rel", 32'(m68k_dtack_n), 32'h1);

    // Z80 write, then 68K reads it back.
    we_snap = we_cnt;
    z80_start(1'b1, 11'h010, 8'hC3);
    #1;
    chk("wrz_wait_n0", 32'(z80_wait_n), 32'h0);
    tick(2);
    chk("wrz_wait_n2", 32'(z80_wait_n), 32'h0);
    tick(1);
    chk("wrz_wait_n3", 32'(z80_wait_n), 32'h1);
    chk("wrz_mem", 32'(mem[11'h010]), 32'hC3);
    chk("wrz_we_cnt", 32'(we_cnt - we_snap), 32'd1);
    z80_release();
    tick(1);
    m68k_start(1'b1, 1'b0, 11'h010, 8'h00);
    tick(3);
    chk("rdback_dtack_n", 32'(m68k_dtack_n), 32'h0);
    chk("rdback_dout", 32'(m68k_dout), 32'hFFC3);
    m68k_release();
    tick(2);

    // Simultaneous after reset: 68K wins, Z80 follows.
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    m68k_start(1'b1, 1'b0, 11'h123, 8'h00);
    z80_start(1'b0, 11'h010, 8'h00);
    tick(3);
    chk("sim1_m_dtack_n", 32'(m68k_dtack_n), 32'h0);
    chk("sim1_m_dout", 32'(m68k_dout), 32'hFF5A);
    chk("sim1_z_wait_n3", 32'(z80_wait_n), 32'h0);
    tick(2);
    chk("sim1_z_wait_n5", 32'(z80_wait_n), 32'h0);
    tick(1);
    chk("sim1_z_wait_n6", 32'(z80_wait_n), 32'h1);
    chk("sim1_z_dout", 32'(z80_dout), 32'hC3);
    m68k_release();
    z80_release();
    tick(2);

    // Upper-byte-only 68K write: acknowledged, RAM untouched.
    we_snap = we_cnt;
    m68k_start(1'b0, 1'b1, 11'h020, 8'h77);
    tick(3);
    chk("ub_dtack_n", 32'(m68k_dtack_n), 32'h0);
    chk("ub_mem", 32'(mem[11'h020]), 32'h11);
    chk("ub_we_cnt", 32'(we_cnt - we_snap), 32'd0);
    m68k_release();
    tick(2);

    // Contention with 68K granted last: Z80 wins this round.
    m68k_start(1'b1, 1'b0, 11'h020, 8'h00);
    z80_start(1'b0, 11'h123, 8'h00);
    tick(3);
    chk("sim2_z_wait_n3", 32'(z80_wait_n), 32'h1);
    chk("sim2_z_dout", 32'(z80_dout), 32'h5A);
    chk("sim2_m_dtack_n3", 32'(m68k_dtack_n), 32'h1);
    tick(3);
    chk("sim2_m_dtack_n6", 32'(m68k_dtack_n), 32'h0);
    chk("sim2_m_dout", 32'(m68k_dout), 32'hFF11);
    m68k_release();
    z80_release();
    tick(2);

    // 68K holds cs long after ack: one write only, Z80 served meanwhile.
    we_snap = we_cnt;
    m68k_start(1'b0, 1'b0, 11'h030, 8'h9C);
    tick(3);
    chk("hold_dtack_n", 32'(m68k_dtack_n), 32'h0);
    z80_start(1'b1, 11'h031, 8'h44);
    tick(3);
    chk("hold_z_wait_n", 32'(z80_wait_n), 32'h1);
    z80_release();
    tick(7);
    chk("hold_dtack_still", 32'(m68k_dtack_n), 32'h0);
    chk("hold_mem30", 32'(mem[11'h030]), 32'h9C);
    chk("hold_mem31", 32'(mem[11'h031]), 32'h44);
    chk("hold_we_cnt", 32'(we_cnt - we_snap), 32'd2);
    m68k_release();
    tick(2);

    // Reset during ACCESS of a 68K write: no write lands.
    m68k_start(1'b0, 1'b0, 11'h040, 8'hAA);
    tick(1);
    chk("rmid_we_pre", 32'(ram_we), 32'h1);
    we_snap = we_cnt;
    reset_n = 1'b0;
    #1;
    chk("rmid_we", 32'(ram_we), 32'h0);
    chk("rmid_dtack_n", 32'(m68k_dtack_n), 32'h1);
    chk("rmid_ram_addr", 32'(ram_addr), 32'h000);
    m68k_release();
    tick(2);
    reset_n = 1'b1;
    tick(4);
    chk("rmid_mem", 32'(mem[11'h040]), 32'h55);
    chk("rmid_we_cnt", 32'(we_cnt - we_snap), 32'd0);
    chk("rmid_dtack_idle", 32'(m68k_dtack_n), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_shared_ram_arbiter
